// File: rtl/if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_stage
// Description : Instruction-fetch stage with IF/ID pipeline register.
//               Holds the PC, issues instruction-memory requests, handles
//               load-use stalls and decode-stage branch redirects/flushes,
//               and injects NOP_WORD bubbles into decode.
//               Optional macro IF_PERF_CNT_EN adds fetch/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam logic [1:0]  S_BOOT       = 2'd0;
    localparam logic [1:0]  S_FETCH      = 2'd1;
    localparam logic [1:0]  S_WAIT       = 2'd2;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_PC_STEP    = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_id_instr_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_pc4_nxt;
    logic        w_id_valid_nxt;
    logic        w_fetch_evt;
    logic        w_bubble_evt;

    // State, PC and IF/ID register; reset aborts any outstanding fetch at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC & c_ALIGN_MASK;
            r_id_instr <= NOP_WORD;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_id_instr <= w_id_instr_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_pc4   <= w_id_pc4_nxt;
            r_id_valid <= w_id_valid_nxt;
        end
    end

    // Next-state logic: branch flush beats stall, stall beats normal fetch
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_id_instr_nxt = r_id_instr;
        w_id_pc_nxt    = r_id_pc;
        w_id_pc4_nxt   = r_id_pc4;
        w_id_valid_nxt = r_id_valid;
        w_fetch_evt    = 1'b0;
        w_bubble_evt   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH, S_WAIT: begin
                if (br_taken) begin
                    // Redirect; any word returned this cycle is dropped
                    w_pc_nxt       = br_target & c_ALIGN_MASK;
                    w_id_instr_nxt = NOP_WORD;
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_FETCH;
                    w_bubble_evt   = 1'b1;
                end else if (stall) begin
                    // Hold everything; a returned word is refetched later
                    w_state_nxt = r_state;
                end else if (imem_ready) begin
                    w_id_instr_nxt = imem_rdata;
                    w_id_pc_nxt    = r_pc;
                    w_id_pc4_nxt   = r_pc + c_PC_STEP;
                    w_id_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + c_PC_STEP;
                    w_state_nxt    = S_FETCH;
                    w_fetch_evt    = 1'b1;
                end else begin
                    // Memory not ready: bubble into decode, keep address stable
                    w_id_instr_nxt = NOP_WORD;
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_WAIT;
                    w_bubble_evt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign imem_req  = (r_state == S_FETCH) || (r_state == S_WAIT);
    assign imem_addr = r_pc;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc4;
    assign id_valid  = r_id_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_bubble_cnt;

    // Count latched fetches and latched bubbles; stall-hold cycles excluded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt  <= 32'd0;
            r_perf_bubble_cnt <= 32'd0;
        end else begin
            if (w_fetch_evt) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_bubble_evt) begin
                r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch_cnt;
    assign perf_bubble_cnt = r_perf_bubble_cnt;
`else
    logic w_evt_unused;
    assign w_evt_unused = w_fetch_evt | w_bubble_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_stage
// Description : Self-checking bench for if_id_fetch_stage. Directed scenarios
//               followed by randomized stall/branch/ready traffic, compared
//               against a cycle-level reference model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_cmp;
    int n_err;

    // Reference model state
    logic        m_booted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic        m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;

    if_id_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 1'b0;
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_idpc   = 32'h0;
        m_idpc4  = 32'h0;
        m_valid  = 1'b0;
        m_fetch  = 32'h0;
        m_bubble = 32'h0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".imem_req"}, {31'b0, imem_req}, {31'b0, m_booted});
        chk({where, ".imem_addr"}, imem_addr, m_pc);
        chk({where, ".id_instr"}, id_instr, m_instr);
        chk({where, ".id_pc"}, id_pc, m_idpc);
        chk({where, ".id_pc4"}, id_pc4, m_idpc4);
        chk({where, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
        chk({where, ".perf_fetch"}, perf_fetch_cnt, m_fetch);
        chk({where, ".perf_bubble"}, perf_bubble_cnt, m_bubble);
`endif
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check after it
    task automatic step(input string where, input logic s, input logic b,
                        input logic [31:0] t, input logic r, input logic [31:0] d);
        stall      = s;
        br_taken   = b;
        br_target  = t;
        imem_ready = r;
        imem_rdata = d;
        @(posedge clk);
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (b) begin
            m_pc     = {t[31:2], 2'b00};
            m_instr  = 32'h0;
            m_valid  = 1'b0;
            m_bubble = m_bubble + 32'd1;
        end else if (s) begin
            m_pc = m_pc;
        end else if (r) begin
            m_instr = d;
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fetch = m_fetch + 32'd1;
        end else begin
            m_instr  = 32'h0;
            m_valid  = 1'b0;
            m_bubble = m_bubble + 32'd1;
        end
        #1;
        check_all(where);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic fetch(input string where);
        step(where, 1'b0, 1'b0, 32'h0, 1'b1, word_of(imem_addr));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot cycle then free-running fetch 0,4,8,C
        step("boot", 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("boot_addr0", imem_addr, 32'h0);
        fetch("f0");
        chk("f0_idpc", id_pc, 32'h0);
        chk("f0_addr", imem_addr, 32'h4);
        fetch("f4");
        chk("f4_pc4", id_pc4, 32'h8);
        fetch("f8");
        fetch("fC");

        // Three not-ready cycles at 0x10, then the word arrives
        for (int i = 0; i < 3; i++) begin
            step("wait10", 1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD0_0000);
            chk("wait10_addr", imem_addr, 32'h10);
        end
        step("ready10", 1'b0, 1'b0, 32'h0, 1'b1, 32'hE281_1001);
        chk("ready10_instr", id_instr, 32'hE281_1001);
        chk("ready10_pc", id_pc, 32'h10);
        fetch("f14");
        fetch("f18");
        fetch("f1C");

        // Two-cycle stall with memory ready, then 0x20 fetched once
        step("stall1", 1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        step("stall2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
        chk("stall_idpc", id_pc, 32'h1C);
        chk("stall_addr", imem_addr, 32'h20);
        fetch("f20");
        chk("f20_idpc", id_pc, 32'h20);

        // Branch wins over a simultaneous stall; low target bits dropped
        step("br103", 1'b1, 1'b1, 32'h103, 1'b1, 32'h3333_3333);
        chk("br103_addr", imem_addr, 32'h100);
        chk("br103_valid", {31'b0, id_valid}, 32'h0);
        fetch("f100");
        chk("f100_idpc", id_pc, 32'h100);

        // Branch while waiting on 0x40: late word must be discarded
        step("br40", 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        step("wait40", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("br80", 1'b0, 1'b1, 32'h80, 1'b1, 32'h4444_4444);
        chk("br80_addr", imem_addr, 32'h80);
        chk("br80_instr", id_instr, 32'h0);
        fetch("f80");
        chk("f80_idpc", id_pc, 32'h80);

        // PC wrap at the top of the address space
        step("brtop", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        fetch("ftop");
        chk("ftop_pc4", id_pc4, 32'h0);
        chk("ftop_addr", imem_addr, 32'h0);

        // Reset asserted in the middle of a WAIT cycle takes effect at once
        step("wait0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        step("rboot", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 $urandom,
                 ($urandom_range(0, 9) < 7),
                 $urandom);
        end

`ifdef IF_PERF_CNT_EN
        // Counter scenario: 5 fetches, 2 wait cycles, 1 flush
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("pboot", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) fetch("pfetch");
        step("pwait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("pwait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("pflush", 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
        step("pstall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("perf_fetch5", perf_fetch_cnt, 32'd5);
        chk("perf_bubble3", perf_bubble_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register.
- Holds the PC, drives the instruction-memory request, and registers the fetched word into the decode stage that feeds the control unit.
- Handles load-use stalls from the hazard unit and branch redirects/flushes from decode.
- Inserts the all-zero NOP word whenever decode must see a bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, word presented to decode on a bubble or flush; decoded as NOP downstream.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit hold; freezes PC and the IF/ID register.
- br_taken  in  1  branch resolved taken in decode; redirect fetch.
- br_target  in  32  branch target address; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; equals the PC.
- imem_rdata  in  32  instruction word; valid only in a cycle where imem_ready=1.
- imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle.
- id_instr  out  32  registered instruction to decode.
- id_pc  out  32  address of id_instr.
- id_pc4  out  32  id_pc+4, used as the link value.
- id_valid  out  1  1 = id_instr is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, imem_req=0.
  - id_instr=NOP_WORD, id_pc=0, id_pc4=0, id_valid=0.
- FSM states:
  - BOOT: one cycle with imem_req=0, then go to FETCH. br_taken/stall are ignored in BOOT.
  - FETCH: imem_req=1, imem_addr=pc.
  - WAIT: entered when FETCH sees imem_ready=0. imem_req stays 1 and imem_addr stays stable until ready. Return to FETCH on ready.
- Priority each cycle in FETCH/WAIT is br_taken > stall > normal.
- br_taken=1:
  - pc <= {br_target[31:2],2'b00}.
  - IF/ID <= NOP_WORD with id_valid=0 (flush), regardless of stall or imem_ready.
  - Any word returned this cycle is discarded.
  - Next state is FETCH. imem_addr may change mid-WAIT; memory treats this as an abort.
- stall=1, br_taken=0:
  - pc and the IF/ID register hold their values.
  - If imem_ready=1, the returned word is discarded and refetched later; no buffering.
  - State is unchanged, so WAIT stays WAIT.
- Normal case, imem_ready=1:
  - id_instr<=imem_rdata, id_pc<=pc, id_pc4<=pc+4, id_valid<=1.
  - pc<=pc+4.
  - Latency: address issued in cycle N with ready → word appears on id_instr at cycle N+1.
- Normal case, imem_ready=0:
  - IF/ID <= NOP_WORD, id_valid=0 (bubble); id_pc/id_pc4 hold.
  - State -> WAIT.
- Arithmetic: PC increments modulo 2^32, so 32'hFFFF_FFFC+4 = 0. id_pc4 wraps the same way.
- Reset asserted mid-WAIT aborts immediately: imem_req drops asynchronously and all registers take their reset values.
- Deassertion is synchronized by the system reset synchronizer, not inside this block.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_fetch_cnt increments on each cycle that latches id_valid<=1.
  - perf_bubble_cnt increments on each cycle that latches id_valid<=0 from a flush or wait. Stall-hold cycles do not count.
  - Both counters reset to 0 asynchronously and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then free-run with imem_ready=1 and RESET_PC=0:
  - imem_req=0 for 1 cycle.
  - imem_addr then sequences 0,4,8.
  - id_pc is 0,4 one cycle later with id_valid=1 and id_pc4=id_pc+4.
- imem_ready=0 for 3 cycles at addr 0x10:
  - imem_addr holds 0x10 and id_valid=0 with id_instr=0 for those cycles.
  - On ready with word 0xE2811001, id_instr=0xE2811001 and id_pc=0x10.
- stall=1 for 2 cycles with PC=0x20 and id_pc=0x1C:
  - PC, id_instr and id_pc=0x1C hold, even with imem_ready=1.
  - After release, 0x20 is fetched once.
- br_taken=1 with br_target=0x103 and stall=1 in the same cycle:
  - Next cycle id_valid=0, id_instr=0, imem_addr=0x100.
  - The following fetch returns id_pc=0x100.
- Branch during WAIT: imem_ready=0 at 0x40, br_taken with target 0x80:
  - imem_addr switches to 0x80 and the late word for 0x40 never reaches IF/ID.
- PC wrap: after a branch to 0xFFFFFFFC with ready, id_pc4=0 and the next imem_addr=0. Then assert rst_n=0 mid-WAIT → all outputs return to reset values immediately.
- With IF_PERF_CNT_EN: run 5 fetches, 2 wait cycles and 1 flush → perf_fetch_cnt=5, perf_bubble_cnt=3.
